// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: ready-handshake data-memory
// access with stall and timeout, then registers the writeback value.
module mem_wb_stage #(
  parameter logic [31:0] RESET_VALUE    = '0,
  parameter int          ADDR_BITS      = 12,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inRegWrEn,
  input  logic [3:0]           inWrReg,
  input  logic [1:0]           inMulSel,
  input  logic [31:0]          inAluOut,
  input  logic [31:0]          inData2Out,
  input  logic [31:0]          inPC,
  input  logic                 inIsLoad,
  input  logic                 inIsStore,
  output logic                 memReq,
  output logic                 memWrEn,
  output logic [ADDR_BITS-1:0] memAddr,
  output logic [31:0]          memWrData,
  input  logic [31:0]          memRdData,
  input  logic                 memReady,
  output logic                 memStall,
  output logic                 outRegWrEn,
  output logic [3:0]           outWrReg,
  output logic [31:0]          outWrData,
  output logic                 busErr,
  output logic                 misalignErr
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic        mem_op, acc, misalign, timeout;
  logic        wb_en;
  logic [31:0] wb_data;

  assign mem_op   = inIsLoad | inIsStore;
  assign acc      = mem_op & (inAluOut[1:0] == 2'b00);
  assign misalign = mem_op & (inAluOut[1:0] != 2'b00);
  assign timeout  = (state == WAIT) & (wait_cnt == TMO);

  // Request is combinational so it must be gated by reset explicitly.
  assign memReq    = acc & ~reset;
  assign memWrEn   = ~inIsLoad;
  assign memAddr   = inAluOut[ADDR_BITS+1:2];
  assign memWrData = inData2Out;
  assign memStall  = memReq & ~memReady & ~timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    unique case (state)
      IDLE: begin
        wait_cnt_next = '0;
        if (acc && !memReady) state_next = WAIT;
      end
      WAIT: begin
        wait_cnt_next = wait_cnt + 8'd1;
        if (memReady || timeout || !acc) begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wb_data = inAluOut;
    unique case (inMulSel)
      2'b01:   wb_data = timeout ? 32'h0 : memRdData;
      2'b10:   wb_data = inPC + 32'd4;
      default: wb_data = inAluOut;
    endcase
  end

  assign wb_en = inRegWrEn & ~misalign & ~timeout;

  // Stalled edges insert a bubble; index and data hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outRegWrEn  <= RESET_VALUE[0];
      outWrReg    <= RESET_VALUE[3:0];
      outWrData   <= RESET_VALUE;
      busErr      <= 1'b0;
      misalignErr <= 1'b0;
    end else begin
      if (memStall) begin
        outRegWrEn <= 1'b0;
      end else begin
        outRegWrEn <= wb_en;
        outWrReg   <= inWrReg;
        outWrData  <= wb_data;
      end
      if (timeout)  busErr      <= 1'b1;
      if (misalign) misalignErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU/JAL writeback, wait-state load,
// timeout, zero-wait accesses, misaligned store and asynchronous reset.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inRegWrEn, inIsLoad, inIsStore, memReady;
  logic [3:0]  inWrReg;
  logic [1:0]  inMulSel;
  logic [31:0] inAluOut, inData2Out, inPC, memRdData;
  logic        memReq, memWrEn, memStall, outRegWrEn, busErr, misalignErr;
  logic [11:0] memAddr;
  logic [31:0] memWrData, outWrData;
  logic [3:0]  outWrReg;

  int total = 0;
  int bad   = 0;
  int stalls;

  mem_wb_stage dut (
    .clk(clk), .reset(reset),
    .inRegWrEn(inRegWrEn), .inWrReg(inWrReg), .inMulSel(inMulSel),
    .inAluOut(inAluOut), .inData2Out(inData2Out), .inPC(inPC),
    .inIsLoad(inIsLoad), .inIsStore(inIsStore),
    .memReq(memReq), .memWrEn(memWrEn), .memAddr(memAddr), .memWrData(memWrData),
    .memRdData(memRdData), .memReady(memReady), .memStall(memStall),
    .outRegWrEn(outRegWrEn), .outWrReg(outWrReg), .outWrData(outWrData),
    .busErr(busErr), .misalignErr(misalignErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    inRegWrEn = 0; inWrReg = 0; inMulSel = 0; inAluOut = 0; inData2Out = 0;
    inPC = 0; inIsLoad = 0; inIsStore = 0; memReady = 0; memRdData = 0;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_wren", 32'(outRegWrEn), 0);
    chk("rst_data", outWrData, 0);
    chk("rst_reg", 32'(outWrReg), 0);
    chk("rst_req", 32'(memReq), 0);

    // ALU op
    inMulSel = 2'b00; inAluOut = 32'h1234; inWrReg = 5; inRegWrEn = 1;
    #1;
    chk("alu_req", 32'(memReq), 0);
    chk("alu_stall", 32'(memStall), 0);
    tick();
    chk("alu_data", outWrData, 32'h1234);
    chk("alu_reg", 32'(outWrReg), 5);
    chk("alu_wren", 32'(outRegWrEn), 1);

    // JAL, including PC+4 wrap
    inMulSel = 2'b10; inPC = 32'h40; inWrReg = 1;
    tick();
    chk("jal_data", outWrData, 32'h44);
    inPC = 32'hFFFF_FFFC;
    tick();
    chk("jal_wrap", outWrData, 32'h0);

    // Load, memReady on 4th cycle
    clr();
    inIsLoad = 1; inAluOut = 32'h10; inMulSel = 2'b01; inWrReg = 7; inRegWrEn = 1;
    #1;
    chk("ld_addr", 32'(memAddr), 4);
    chk("ld_req", 32'(memReq), 1);
    chk("ld_wren", 32'(memWrEn), 0);
    stalls = 0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin memReady = 1; memRdData = 32'hCAFE; end
      #1;
      if (memStall) stalls++;
      tick();
      if (i == 1) chk("ld_bub_hold", outWrData, 32'h0);
      if (i < 4) chk("ld_bubble", 32'(outRegWrEn), 0);
    end
    chk("ld_stalls", stalls, 3);
    chk("ld_data", outWrData, 32'hCAFE);
    chk("ld_wb_en", 32'(outRegWrEn), 1);
    chk("ld_reg", 32'(outWrReg), 7);

    // Timeout
    clr();
    inIsLoad = 1; inAluOut = 32'h20; inMulSel = 2'b01; inWrReg = 9; inRegWrEn = 1;
    memRdData = 32'hDEAD;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!memStall) break;
      stalls++;
      tick();
    end
    chk("to_stalls", stalls, 16);
    chk("to_busErr_pre", 32'(busErr), 0);
    tick();
    clr();
    chk("to_busErr", 32'(busErr), 1);
    chk("to_wren", 32'(outRegWrEn), 0);
    chk("to_data", outWrData, 32'h0);

    // Back in IDLE: zero-wait load completes without stall
    inIsLoad = 1; inAluOut = 32'h30; inMulSel = 2'b01; inWrReg = 2; inRegWrEn = 1;
    memReady = 1; memRdData = 32'hBEEF;
    #1;
    chk("zw_stall", 32'(memStall), 0);
    tick();
    chk("zw_data", outWrData, 32'hBEEF);
    chk("zw_wren", 32'(outRegWrEn), 1);
    chk("busErr_sticky", 32'(busErr), 1);

    // Zero-wait store
    clr();
    inIsStore = 1; inAluOut = 32'h100; inData2Out = 32'h55; memReady = 1;
    #1;
    chk("st_wren", 32'(memWrEn), 1);
    chk("st_wdata", memWrData, 32'h55);
    chk("st_addr", 32'(memAddr), 32'h40);
    chk("st_stall", 32'(memStall), 0);
    tick();
    chk("st_wb_en", 32'(outRegWrEn), 0);

    // Misaligned store
    clr();
    chk("mis_pre", 32'(misalignErr), 0);
    inIsStore = 1; inAluOut = 32'h6; inRegWrEn = 1; inWrReg = 3;
    #1;
    chk("mis_req", 32'(memReq), 0);
    chk("mis_stall", 32'(memStall), 0);
    tick();
    chk("mis_err", 32'(misalignErr), 1);
    chk("mis_wren", 32'(outRegWrEn), 0);
    chk("mis_data", outWrData, 32'h6);

    // Reset mid-WAIT
    clr();
    inIsLoad = 1; inAluOut = 32'h40; inMulSel = 2'b01; inRegWrEn = 1; inWrReg = 4;
    tick(); tick();
    #2;
    chk("mw_req_pre", 32'(memReq), 1);
    reset = 1'b1;
    #1;
    chk("mw_req", 32'(memReq), 0);
    chk("mw_stall", 32'(memStall), 0);
    chk("mw_data", outWrData, 0);
    chk("mw_reg", 32'(outWrReg), 0);
    chk("mw_busErr", 32'(busErr), 0);
    chk("mw_misErr", 32'(misalignErr), 0);
    clr();
    #1;
    reset = 1'b0;
    tick();
    chk("post_wren", 32'(outRegWrEn), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
